jpeg_quant_zigzag: RTL and testbench
====================================

# jpeg_quant_zigzag

Encoder-side forward quantizer and zigzag reorderer; the inverse of the decoder's inverse-zigzag/dequant path. It accepts a stream of 64 row-major DCT coefficients per 8x8 block and divides each by its quantization table entry with rounding. It emits the 64 quantized values in zigzag order for the entropy encoder. A two-bank ping-pong buffer lets one block be written while the previous one is read out, so blocks can stream back-to-back.

## Interface
- WIDTH_IN, 32, signed width of incoming DCT coefficients
- WIDTH_Q, 16, unsigned width of each quantization table entry
- WIDTH_OUT, 16, signed width of quantized output coefficients
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data holds a valid coefficient
- in_ready  output  1  block can accept a coefficient this cycle
- in_data  input  WIDTH_IN  signed coefficient, row-major order (index 0..63)
- quant_flat  input  WIDTH_Q*64  Q table, row-major, entry i at bits [i*WIDTH_Q +: WIDTH_Q]
- out_valid  output  1  out_data holds a valid quantized coefficient
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WIDTH_OUT  signed quantized coefficient, zigzag order
- out_last  output  1  high with the 64th (zigzag index 63) output of a block

## Operation
- Write side: a 6-bit write counter and a write-bank pointer. A beat transfers when in_valid && in_ready and stores in_data at row-major address = counter. On the 64th beat the counter wraps to 0, the bank's full flag sets, and the write pointer toggles.
- in_ready = !full[write bank].
- Read side states: IDLE (read bank not full) and DRAIN (emitting). IDLE->DRAIN when full[read bank] is set. In DRAIN, zigzag index k runs 0..63. The address is the standard JPEG zigzag map (k=0..5 -> 0,1,8,16,9,2, ..., k=63 -> 63).
- When the output beat with k=63 transfers, full[read bank] clears and the read pointer toggles. The state returns to IDLE, or stays in DRAIN at k=0 if the other bank is already full.
- Arithmetic per coefficient x at row-major address a, with Q = quant_flat entry a:
  - Q=0 is treated as Q=1.
  - m = |x| (WIDTH_IN+1 bits, so the most negative value is exact).
  - q = (m + Q/2) / Q, or m / Q without rounding (see Configuration).
  - The result is negated if x<0, giving sign-symmetric rounding.
  - The result saturates to [-(2^(WIDTH_OUT-1)-1), 2^(WIDTH_OUT-1)-1].
- quant_flat must be stable from the first output of a block until its out_last transfers. The block does not latch it.
- Simultaneous write and read of different banks is always legal. Write and read never target the same bank.

## Timing
- Reset values: in_ready=1 once rst deasserts (both banks empty). out_valid=0, out_data=0, out_last=0. All counters and pointers are 0 and both full flags are 0.
- Reset mid-operation discards any partial write block and any block being drained. No output beat is emitted after rst rises.
- Latency: if the 64th input beat transfers on edge N, out_valid for k=0 is high after edge N+2 (output register plus one pipeline stage).
- Throughput: one output per cycle while out_ready=1, with no bubble between k=63 of one block and k=0 of the next if that block is already full.
- out_valid and out_data hold steady while out_ready=0. An internal skid/stall of the fetch pipeline preserves this.
- With both banks full, in_ready=0 until out_last transfers. in_ready rises on the cycle after that transfer.

## Configuration
- JPEG_QZ_ROUND_EN defined: q = (|x| + Q/2)/Q, which rounds half away from zero.
- JPEG_QZ_ROUND_EN undefined: q = |x|/Q, which truncates toward zero. All other behaviour is identical.

## Test plan
- Zigzag order: in_data[i]=i*16, all Q=16, out_ready=1 -> outputs 0,1,8,16,9,2,... per zigzag map, ending with 63. out_last is high only on the 64th output, and the first out_valid comes 2 cycles after the last input.
- Rounding: x=-24, x=24, x=23, Q=16:
  - With JPEG_QZ_ROUND_EN -> -2, 2, 1.
  - Without -> -1, 1, 1.
- Saturation/Q=0: x=100000 with Q=1 -> 32767; x=-100000 with Q=1 -> -32767; x=5 with Q=0 -> 5.
- Back-to-back: 3 blocks streamed continuously, out_ready=1 -> 192 outputs with no gaps after the first.
- Backpressure: out_ready=0 for 10 cycles at k=20, input streaming -> out_data held constant during the stall. The second block is fully accepted, then in_ready drops during the third block until the first block's out_last transfers. No data is lost.
- Reset mid-block: rst pulsed after 30 inputs of block 1 and during the drain of block 0 -> outputs go low immediately. A fresh block afterward yields the correct 64 outputs.

Source files
------------

// File: rtl/jpeg_quant_zigzag.sv
// -----------------------------------------------------------------------------
// jpeg_quant_zigzag
//
// Encoder-side forward quantizer and zigzag reorderer. Blocks of 64 signed DCT
// coefficients arrive in row-major order. Each coefficient is divided by its
// quantization table entry, and the 64 results leave in JPEG zigzag order. A
// two-bank ping-pong buffer lets one block be written while the previous block
// is read out, so blocks can stream back-to-back.
//
// Parameters
//   WIDTH_IN   signed width of incoming DCT coefficients
//   WIDTH_Q    unsigned width of one quantization table entry
//   WIDTH_OUT  signed width of quantized output coefficients
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    in_data holds a valid coefficient
//   in_ready    a coefficient can be accepted this cycle
//   in_data     signed coefficient, row-major index 0..63
//   quant_flat  Q table, row-major, entry i at [i*WIDTH_Q +: WIDTH_Q]; it must
//               stay stable while a block is being emitted (it is not latched)
//   out_valid   out_data holds a valid quantized coefficient
//   out_ready   downstream accepts out_data this cycle
//   out_data    signed quantized coefficient, zigzag order
//   out_last    marks zigzag index 63 of a block
//
// Build option
//   JPEG_QZ_ROUND_EN  defined:   q = (|x| + Q/2) / Q  (round half away from 0)
//                     undefined: q = |x| / Q          (truncate toward 0)
//
// Read pipeline: fetch (memory read into stage 1) -> divide/saturate ->
// output register. A block's last input beat on edge N gives out_valid for
// zigzag index 0 after edge N+2.
// -----------------------------------------------------------------------------
module jpeg_quant_zigzag #(
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_Q   = 16,
  parameter int WIDTH_OUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH_IN-1:0]  in_data,
  input  logic [WIDTH_Q*64-1:0]       quant_flat,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH_OUT-1:0] out_data,
  output logic                        out_last
);

  // Magnitude needs one extra bit so |most negative input| is exact; the
  // numerator needs one more for the rounding term.
  localparam int WM = WIDTH_IN + 1;
  localparam int WN = WIDTH_IN + 2;

  // Symmetric saturation bound: +/-(2^(WIDTH_OUT-1) - 1).
  localparam logic [WN-1:0] SAT_MAX = (WN'(1) << (WIDTH_OUT - 1)) - WN'(1);

  // Read-side states.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // Zigzag index k -> row-major address.
  localparam logic [5:0] ZZ_MAP [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // ---------------------------------------------------------------------------
  // Storage: bank b occupies addresses {b, 6'addr}.
  // ---------------------------------------------------------------------------
  logic signed [WIDTH_IN-1:0] r_mem [128];

  // Write side
  logic [5:0] r_wr_cnt;
  logic       r_wr_bank;
  logic [1:0] r_full;
  logic       w_wr_fire;

  // Read side: the fetch pointer may move on to the next bank while the last
  // coefficients of the previous block are still in the pipeline; the
  // release pointer frees a bank only when its out_last transfers.
  logic [0:0] r_state;
  logic       r_fetch_bank;
  logic [5:0] r_fetch_k;
  logic       r_rd_bank;
  logic       w_fetch;
  logic       w_release;

  // Stage 1: coefficient fetched from memory, with its table address.
  logic                       r_s1_valid;
  logic signed [WIDTH_IN-1:0] r_s1_x;
  logic [5:0]                 r_s1_addr;
  logic                       r_s1_last;

  // Pipeline advance enables.
  logic w_out_adv;
  logic w_s1_adv;

  // Arithmetic between stage 1 and the output register.
  logic [WIDTH_Q-1:0]          w_q_raw;
  logic [WIDTH_Q-1:0]          w_q_eff;
  logic                        w_neg;
  logic [WM-1:0]               w_x_ext;
  logic [WM-1:0]               w_mag;
  logic [WN-1:0]               w_num;
  logic [WN-1:0]               w_quot;
  logic [WIDTH_OUT-1:0]        w_sat;
  logic signed [WIDTH_OUT-1:0] w_q_result;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign in_ready  = !r_full[r_wr_bank];
  assign w_wr_fire = in_valid && in_ready;
  assign w_release = out_valid && out_ready && out_last;

  // The output register loads whenever it is empty or being consumed; stage 1
  // loads whenever it is empty or moving into the output register. A stall
  // therefore freezes both stages and out_data holds its value.
  assign w_out_adv = !out_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_out_adv;

  // IDLE starts fetching on the same cycle the bank becomes full so the
  // first output appears two edges after the last input beat.
  assign w_fetch = w_s1_adv && ((r_state == ST_DRAIN) || r_full[r_fetch_bank]);

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt  <= 6'd0;
      r_wr_bank <= 1'b0;
    end else if (w_wr_fire) begin
      r_wr_cnt <= r_wr_cnt + 6'd1;
      if (r_wr_cnt == 6'd63) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // NOTE: the coefficient memory has no reset; full flags gate every read,
  // so stale contents are never observed and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[{r_wr_bank, r_wr_cnt}] <= in_data;
    end
  end

  // Writer and reader always own different banks, so set and clear never
  // target the same flag in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 2'b00;
    end else begin
      if (w_wr_fire && (r_wr_cnt == 6'd63)) begin
        r_full[r_wr_bank] <= 1'b1;
      end
      if (w_release) begin
        r_full[r_rd_bank] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_bank <= 1'b0;
    end else if (w_release) begin
      r_rd_bank <= ~r_rd_bank;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_fetch_bank <= 1'b0;
      r_fetch_k    <= 6'd0;
    end else if (w_fetch) begin
      if (r_fetch_k == 6'd63) begin
        r_fetch_k    <= 6'd0;
        r_fetch_bank <= ~r_fetch_bank;
        // Continue straight into the other bank if it is already waiting.
        r_state      <= r_full[~r_fetch_bank] ? ST_DRAIN : ST_IDLE;
      end else begin
        r_fetch_k <= r_fetch_k + 6'd1;
        r_state   <= ST_DRAIN;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: memory read
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_addr  <= 6'd0;
      r_s1_last  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_fetch;
      if (w_fetch) begin
        r_s1_x    <= r_mem[{r_fetch_bank, ZZ_MAP[r_fetch_k]}];
        r_s1_addr <= ZZ_MAP[r_fetch_k];
        r_s1_last <= (r_fetch_k == 6'd63);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Quantize: sign/magnitude divide so rounding is symmetric about zero.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    w_q_raw = quant_flat[r_s1_addr * WIDTH_Q +: WIDTH_Q];
    // A zero table entry would divide by zero; treat it as 1.
    w_q_eff = (w_q_raw == '0) ? WIDTH_Q'(1) : w_q_raw;
    w_neg   = r_s1_x[WIDTH_IN-1];
    w_x_ext = {r_s1_x[WIDTH_IN-1], r_s1_x};
    w_mag   = w_neg ? (WM'(0) - w_x_ext) : w_x_ext;
`ifdef JPEG_QZ_ROUND_EN
    w_num   = WN'(w_mag) + WN'(w_q_eff >> 1);
`else
    w_num   = WN'(w_mag);
`endif
    w_quot  = w_num / WN'(w_q_eff);
    w_sat   = (w_quot > SAT_MAX) ? SAT_MAX[WIDTH_OUT-1:0] : w_quot[WIDTH_OUT-1:0];
    w_q_result = w_neg ? (WIDTH_OUT'(0) - w_sat) : w_sat;
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (w_out_adv) begin
      out_valid <= r_s1_valid;
      out_last  <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        out_data <= w_q_result;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_quant_zigzag.sv
// -----------------------------------------------------------------------------
// tb_jpeg_quant_zigzag
//
// Self-checking bench for jpeg_quant_zigzag. A behavioural model builds the
// zigzag order by walking anti-diagonals and quantizes with plain integer
// arithmetic; each completed input block pushes its 64 expected outputs onto
// a queue that one compare process checks against the DUT on every cycle with
// out_valid high. Literal expectations pin the model in each directed test.
// The rounding expectations follow the JPEG_QZ_ROUND_EN build option.
// -----------------------------------------------------------------------------
module tb_jpeg_quant_zigzag;

  localparam int WQ = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_data = '0;
  logic [WQ*64-1:0]   quant_flat = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_data;
  logic               out_last;

  jpeg_quant_zigzag dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .quant_flat (quant_flat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model
  // ---------------------------------------------------------------------------
  typedef struct {
    int data;
    bit last;
  } exp_t;

  int   zz [64];
  exp_t exp_q [$];
  int   cap [$];
  int   n_pop  = 0;
  int   blk [64];
  int   wr_idx = 0;

  // Zigzag: walk anti-diagonals, upward on even sums, downward on odd sums.
  function automatic void build_zz();
    int k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 8) ? s : 7; r >= 0 && (s - r) < 8; r--) begin
          zz[k] = r * 8 + (s - r);
          k++;
        end
      end else begin
        for (int r = (s < 8) ? 0 : s - 7; r < 8 && (s - r) >= 0; r++) begin
          zz[k] = r * 8 + (s - r);
          k++;
        end
      end
    end
  endfunction

  function automatic int model_q(input longint x, input longint q);
    longint qq, m, r;
    qq = (q == 0) ? 1 : q;
    m  = (x < 0) ? -x : x;
`ifdef JPEG_QZ_ROUND_EN
    r  = (m + qq / 2) / qq;
`else
    r  = m / qq;
`endif
    if (r > 32767) r = 32767;
    return int'((x < 0) ? -r : r);
  endfunction

  function automatic void push_expected();
    exp_t e;
    for (int k = 0; k < 64; k++) begin
      e.data = model_q(longint'(blk[zz[k]]), longint'(quant_flat[zz[k] * WQ +: WQ]));
      e.last = (k == 63);
      exp_q.push_back(e);
    end
  endfunction

  task automatic set_q(input int a, input int q);
    quant_flat[a * WQ +: WQ] = q[15:0];
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: runs on the falling edge, away from DUT updates.
  // ---------------------------------------------------------------------------
  bit                 stalled = 1'b0;
  logic signed [15:0] held    = '0;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_data_hold", out_data, held);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", exp_q.size(), 1);
        end else begin
          check("out_data", out_data, exp_q[0].data);
          check("out_last", out_last, exp_q[0].last);
          if (out_ready) begin
            cap.push_back(int'(out_data));
            void'(exp_q.pop_front());
            n_pop++;
          end
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic push_beat(input int v, inout int waits);
    bit ok;
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_data  = v;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      waits++;
      t++;
      if (t >= 500) begin
        check("in_ready_timeout", ok, 1);
        break;
      end
    end
    in_valid = 1'b0;
    if (ok) begin
      blk[wr_idx] = v;
      wr_idx++;
      if (wr_idx == 64) begin
        push_expected();
        wr_idx = 0;
      end
    end
  endtask

  task automatic send_block(input int vals [64], output int waits);
    waits = 0;
    for (int i = 0; i < 64; i++) push_beat(vals[i], waits);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check(name, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_drain", out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int v [64];
    int va [64];
    int vb [64];
    int vc [64];
    int w0, w1, w2;
    int base, t;
    int seen, gaps;
    bit stall_done;

    build_zz();
    check("zz_model_k2", zz[2], 8);
    check("zz_model_k20", zz[20], 40);
    check("zz_model_k63", zz[63], 63);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Zigzag order and latency
    for (int a = 0; a < 64; a++) set_q(a, 16);
    for (int i = 0; i < 64; i++) v[i] = i * 16;
    out_ready = 1'b1;
    cap.delete();
    send_block(v, w0);
    @(negedge clk);
    check("latency_edge_n", out_valid, 0);
    @(negedge clk);
    check("latency_edge_n1", out_valid, 0);
    @(negedge clk);
    check("latency_edge_n2", out_valid, 1);
    wait_drain("zigzag_drain");
    check("zigzag_count", cap.size(), 64);
    if (cap.size() == 64) begin
      check("zigzag_k0", cap[0], 0);
      check("zigzag_k1", cap[1], 1);
      check("zigzag_k2", cap[2], 8);
      check("zigzag_k3", cap[3], 16);
      check("zigzag_k4", cap[4], 9);
      check("zigzag_k5", cap[5], 2);
      check("zigzag_k20", cap[20], 40);
      check("zigzag_k63", cap[63], 63);
    end

    // Rounding, saturation and Q=0
    for (int i = 0; i < 64; i++) v[i] = i * 10 - 300;
    v[0] = -24;               // k0,  Q=16
    v[1] = 24;                // k1,  Q=16
    v[2] = 23;                // k5,  Q=16
    v[3] = 100000;  set_q(3, 1);   // k6
    v[4] = -100000; set_q(4, 1);   // k14
    v[5] = 5;       set_q(5, 0);   // k15
    v[8] = -2147483647 - 1; set_q(8, 1);  // k2
    v[16] = -40;              // k3,  Q=16
    v[9] = 7;       set_q(9, 3);   // k4
    cap.delete();
    send_block(v, w0);
    wait_drain("round_drain");
    check("round_count", cap.size(), 64);
    if (cap.size() == 64) begin
`ifdef JPEG_QZ_ROUND_EN
      check("round_m24", cap[0], -2);
      check("round_p24", cap[1], 2);
      check("round_m40", cap[3], -3);
`else
      check("round_m24", cap[0], -1);
      check("round_p24", cap[1], 1);
      check("round_m40", cap[3], -2);
`endif
      check("round_p23", cap[5], 1);
      check("round_7_q3", cap[4], 2);
      check("sat_pos", cap[6], 32767);
      check("sat_neg", cap[14], -32767);
      check("sat_most_neg", cap[2], -32767);
      check("q_zero", cap[15], 5);
    end

    // Back-to-back: three blocks, mixed table including zero entries
    for (int a = 0; a < 64; a++) set_q(a, (a * 5) % 23);
    for (int i = 0; i < 64; i++) begin
      va[i] = (i * i * 37 - 20000);
      vb[i] = (i * i * 37 - 20000) * -3;
      vc[i] = (i * 1013 - 31000) * 7;
    end
    cap.delete();
    fork
      begin
        send_block(va, w0);
        send_block(vb, w1);
        send_block(vc, w2);
      end
      begin
        seen = 0;
        gaps = 0;
        t    = 0;
        forever begin
          @(posedge clk);
          #1;
          t++;
          if (out_valid) seen++;
          else if (seen > 0) gaps++;
          if (seen >= 128 || t > 2000) break;
        end
        check("b2b_seen", seen, 128);
        check("b2b_gaps", gaps, 0);
      end
    join
    wait_drain("b2b_drain");
    check("b2b_count", cap.size(), 192);

    // Backpressure: stall 10 cycles while k=20 of the first block is shown
    cap.delete();
    base       = n_pop;
    stall_done = 1'b0;
    fork
      begin
        send_block(va, w0);
        send_block(vb, w1);
        send_block(vc, w2);
      end
      begin
        t = 0;
        while (n_pop != base + 20 && t < 3000) begin
          @(posedge clk);
          #1;
          t++;
        end
        if (n_pop == base + 20) begin
          out_ready = 1'b0;
          repeat (10) @(posedge clk);
          #1;
          out_ready  = 1'b1;
          stall_done = 1'b1;
        end
      end
    join
    wait_drain("bp_drain");
    check("bp_stall_applied", stall_done, 1);
    check("bp_block2_waits", w1, 0);
    check("bp_block3_waited", (w2 > 0), 1);
    check("bp_count", cap.size(), 192);

    // Reset mid-block while the previous block drains
    for (int a = 0; a < 64; a++) set_q(a, 16);
    for (int i = 0; i < 64; i++) v[i] = i * 16;
    out_ready = 1'b1;
    cap.delete();
    send_block(v, w0);
    w1 = 0;
    for (int i = 0; i < 30; i++) push_beat(-i * 48, w1);
    check("pre_rst_draining", out_valid, 1);
    check("pre_rst_partial", (cap.size() > 0 && cap.size() < 64), 1);
    rst = 1'b1;
    exp_q.delete();
    wr_idx = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    check("mid_rst_still_low", out_valid, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    cap.delete();
    send_block(v, w0);
    wait_drain("post_rst_drain");
    check("post_rst_count", cap.size(), 64);
    if (cap.size() == 64) begin
      check("post_rst_k2", cap[2], 8);
      check("post_rst_k63", cap[63], 63);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
